// File: rtl/sync_fifo_pkt_reader.sv
// Drains a registered-read sync_fifo into a valid/ready stream of fixed-length packets with m_last.
// Optional idle-timeout short-packet flush is enabled by defining SYNC_FIFO_PKT_FLUSH_EN.
module sync_fifo_pkt_reader #(
    parameter int unsigned FIFO_DATA_WIDTH = 32,
    parameter int unsigned FIFO_ADDR_WIDTH = 8,
    parameter int unsigned PKT_LEN         = 16,
    parameter int unsigned FLUSH_TIMEOUT   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [FIFO_ADDR_WIDTH:0]   fifo_data_cnt,
    output logic                       fifo_rd_en,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [FIFO_DATA_WIDTH-1:0] m_data,
    output logic                       m_last,
    output logic [15:0]                pkt_cnt,
    output logic                       busy
);
    localparam int unsigned CW = FIFO_ADDR_WIDTH + 1;
    localparam logic [CW-1:0] PKT_LEN_C = CW'(PKT_LEN);

    if (PKT_LEN < 1 || PKT_LEN > (1 << FIFO_ADDR_WIDTH) ||
        FLUSH_TIMEOUT < 1 || FLUSH_TIMEOUT > 65535) begin : g_param_check
        $error("sync_fifo_pkt_reader: parameter out of range");
    end

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              len, len_nxt;
    logic [CW-1:0]              issue_cnt, issue_cnt_nxt;
    logic                       rd_last;
    logic                       inflight, inflight_last;
    logic [1:0]                 buf_occ;
    logic [1:0]                 wr_idx;
    logic [FIFO_DATA_WIDTH-1:0] buf_data [3];
    logic [2:0]                 buf_last;
    logic [2:0]                 outstanding;
    logic                       pop;

`ifdef SYNC_FIFO_PKT_FLUSH_EN
    logic [15:0] idle_cnt;
    logic        flush_wait, flush_fire;

    assign flush_wait = (state == IDLE) && (fifo_data_cnt != '0) && (fifo_data_cnt < PKT_LEN_C);
    assign flush_fire = flush_wait && (idle_cnt == 16'(FLUSH_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || !flush_wait || flush_fire) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end
`endif

    // Credit includes the read whose data has not yet landed in the buffer.
    assign outstanding = {1'b0, buf_occ} + {2'b00, inflight};
    assign pop         = m_valid && m_ready;
    assign wr_idx      = pop ? (buf_occ - 2'd1) : buf_occ;

    always_comb begin
        state_nxt     = state;
        len_nxt       = len;
        issue_cnt_nxt = issue_cnt;
        fifo_rd_en    = 1'b0;
        rd_last       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_data_cnt >= PKT_LEN_C) begin
                    len_nxt       = PKT_LEN_C;
                    issue_cnt_nxt = '0;
                    state_nxt     = STREAM;
                end
`ifdef SYNC_FIFO_PKT_FLUSH_EN
                else if (flush_fire) begin
                    len_nxt       = fifo_data_cnt;
                    issue_cnt_nxt = '0;
                    state_nxt     = STREAM;
                end
`endif
            end
            STREAM: begin
                fifo_rd_en = !fifo_empty && (outstanding < 3'd3);
                rd_last    = (issue_cnt == (len - CW'(1)));
                if (fifo_rd_en) begin
                    issue_cnt_nxt = issue_cnt + CW'(1);
                    if (rd_last) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            len           <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_occ       <= '0;
            buf_last      <= '0;
            pkt_cnt       <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            len       <= len_nxt;
            issue_cnt <= issue_cnt_nxt;
            inflight  <= fifo_rd_en;
            if (fifo_rd_en) begin
                inflight_last <= rd_last;
            end
            // Shift on pop first; a same-cycle push to wr_idx overrides the shifted slot.
            if (pop) begin
                buf_data[0] <= buf_data[1];
                buf_data[1] <= buf_data[2];
                buf_last[0] <= buf_last[1];
                buf_last[1] <= buf_last[2];
            end
            if (inflight) begin
                buf_data[wr_idx] <= fifo_rd_data;
                buf_last[wr_idx] <= inflight_last;
            end
            if (inflight && !pop) begin
                buf_occ <= buf_occ + 2'd1;
            end else if (!inflight && pop) begin
                buf_occ <= buf_occ - 2'd1;
            end
            if (pop && m_last) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        m_valid = (buf_occ != 2'd0);
        m_data  = buf_data[0];
        m_last  = buf_last[0];
        busy    = (state != IDLE) || (buf_occ != 2'd0) || inflight;
    end

endmodule

// File: doc/sync_fifo_pkt_reader.md
# sync_fifo_pkt_reader

Downstream drain stage for `sync_fifo`: consumes the FIFO read port (registered one-cycle read data, `fifo_empty`, `fifo_data_cnt`) and emits a valid/ready stream grouped into fixed-length packets with a last-beat marker. It absorbs the FIFO read latency in a 3-entry output buffer so back-to-back beats stream at one word per cycle under continuous `m_ready`. It is the block that sits between the FIFO and any packet-oriented consumer (DMA, serializer).

## Interface
- `FIFO_DATA_WIDTH`, 32, data width; matches the FIFO.
- `FIFO_ADDR_WIDTH`, 8, FIFO address width; `fifo_data_cnt` is `FIFO_ADDR_WIDTH+1` bits.
- `PKT_LEN`, 16, beats per full packet; range 1..2^FIFO_ADDR_WIDTH.
- `FLUSH_TIMEOUT`, 64, idle cycles before a short-packet flush (used only with the macro); 1..65535.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty status.
- `fifo_data_cnt` in `FIFO_ADDR_WIDTH+1`: FIFO occupancy.
- `fifo_rd_en` out 1: FIFO read request.
- `fifo_rd_data` in `FIFO_DATA_WIDTH`: FIFO read data, valid the cycle after an accepted read.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: consumer ready.
- `m_data` out `FIFO_DATA_WIDTH`: beat data.
- `m_last` out 1: final beat of the packet.
- `pkt_cnt` out 16: packets completed (last beat accepted); wraps modulo 2^16.
- `busy` out 1: FSM not in IDLE, or buffer/in-flight non-empty.

## Operation
- Reset: `fifo_rd_en`, `m_valid`, `m_data`, `m_last`, `pkt_cnt`, `busy` = 0. FSM goes to IDLE. Buffer, counters, and in-flight flag are cleared. Reset mid-packet discards all buffered and in-flight data without emitting `m_last`.
- FSM states:
  - IDLE: if `fifo_data_cnt >= PKT_LEN`, load `len = PKT_LEN`, clear `issue_cnt`, go to STREAM.
  - STREAM: assert `fifo_rd_en` when `~fifo_empty && (buf_occ + inflight) < 3`. Each accepted read increments `issue_cnt`. When the read with `issue_cnt == len-1` is accepted, go to IDLE. IDLE may start the next packet on the following cycle.
- Read pipeline:
  - An accepted read sets `inflight` for one cycle.
  - Its last flag (`issue_cnt == len-1`) is carried in a 1-cycle delay register.
  - On the next edge, `{last, fifo_rd_data}` is pushed into the 3-entry FIFO-ordered output buffer.
- Output: `m_valid = buf_occ != 0`. `m_data`/`m_last` come from the buffer head. A beat pops on `m_valid && m_ready`. Push and pop in the same cycle leave `buf_occ` unchanged.
- `pkt_cnt` increments on an accepted beat with `m_last = 1`.
- Buffer never overflows: the issue credit counts the in-flight read. The block is the sole FIFO reader; `fifo_empty` gating is a safety stall only.

## Timing
- Threshold met in cycle t (IDLE):
  - STREAM and `fifo_rd_en` in t+1.
  - `fifo_rd_data` valid in t+2.
  - `m_valid` asserted in t+3.
- With `m_ready` held high: one beat per cycle, no bubbles inside a packet. Between consecutive packets there is exactly 1 idle issue cycle (the STREAM->IDLE->STREAM turnaround).
- `m_valid && ~m_ready`: `m_valid`, `m_data`, `m_last` hold stable until accepted. Issue stalls once `buf_occ + inflight = 3`.
- `m_valid` never drops without a handshake.

## Configuration
- `SYNC_FIFO_PKT_FLUSH_EN` defined:
  - IDLE counts consecutive cycles with `0 < fifo_data_cnt < PKT_LEN`; any other condition clears the count.
  - When the count reaches `FLUSH_TIMEOUT`, load `len = fifo_data_cnt` (snapshot), go to STREAM, and emit a short packet whose final beat has `m_last = 1` and which counts in `pkt_cnt`.
- Undefined: only full `PKT_LEN` packets are emitted; residual words stay in the FIFO indefinitely.

## Test plan
- Reset then 16 writes (0x0..0xF), `m_ready = 1`: `m_valid` 3 cycles after the count reaches 16; 16 consecutive beats 0x0..0xF; `m_last` only on 0xF; `pkt_cnt = 1`.
- 48 words preloaded, `m_ready = 1`: three packets; exactly 1 bubble cycle between packets; `pkt_cnt = 3`; FIFO empty at end.
- Backpressure: 16 words, `m_ready` toggled 1/0 each cycle: data order intact, outputs stable while stalled, `fifo_rd_en` never asserted with `buf_occ + inflight = 3`.
- Reset asserted after the 5th beat of a packet with 16 queued words: all outputs 0 next cycle, `pkt_cnt = 0`, no further `m_valid` until the FIFO count reaches 16 again.
- With `SYNC_FIFO_PKT_FLUSH_EN`, `FLUSH_TIMEOUT = 64`: write 5 words, then idle. Required: nothing emitted for 64 cycles, then 5 beats with `m_last` on the 5th and `pkt_cnt = 1`. Without the macro, the same stimulus emits no beats for 1000 cycles.
- `PKT_LEN = 1`: 4 words yield 4 beats, each with `m_last = 1`; `pkt_cnt = 4`.
